// File: rtl/branch_exec.sv
// Short-branch execution unit: evaluates Jcc/JMPS/LOOPcc/JCXZ against latched
// flags and count, writes back the decremented count and redirects fetch.
module branch_exec #(
  parameter int AW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          abort_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          big_i,
  input  logic [7:0]    ir_i,
  input  logic [AW-1:0] disp_i,
  input  logic [AW-1:0] next_eip_i,
  input  logic [AW-1:0] ecx_i,
  input  logic          zf_i,
  input  logic          cf_i,
  input  logic          sf_i,
  input  logic          vf_i,
  input  logic          pf_i,
  output logic          ecx_we_o,
  output logic [AW-1:0] ecx_o,
  output logic          redir_valid_o,
  input  logic          redir_ready_i,
  output logic [AW-1:0] redir_eip_o,
  output logic          done_o,
  output logic          taken_o
);

  typedef enum logic [1:0] {IDLE, EVAL, REDIR, DONE} state_t;

  state_t        state;
  logic          big_q;
  logic [7:0]    ir_q;
  logic [AW-1:0] disp_q;
  logic [AW-1:0] next_eip_q;
  logic [AW-1:0] ecx_q;
  logic          zf_q, cf_q, sf_q, vf_q, pf_q;
  logic          taken_q;
  logic [AW-1:0] redir_eip_q;

  logic          is_jcc, is_jmps, is_loop, is_jcxz;
  logic [AW-1:0] cnt, dec, wb, sum, target;
  logic [15:0]   dec16;
  logic          dec_nz, jcc_cond, cond;

  // The count and decrement wrap in the active operand width; in 16-bit mode
  // the upper half of ECX passes through the write-back untouched.
  always_comb begin
    is_jcc  = (ir_q[7:4] == 4'h7);
    is_jmps = (ir_q == 8'hEB);
    is_loop = (ir_q == 8'hE0) || (ir_q == 8'hE1) || (ir_q == 8'hE2);
    is_jcxz = (ir_q == 8'hE3);
    cnt     = big_q ? ecx_q : {{(AW-16){1'b0}}, ecx_q[15:0]};
    dec16   = ecx_q[15:0] - 16'd1;
    dec     = big_q ? (ecx_q - AW'(1)) : {{(AW-16){1'b0}}, dec16};
    dec_nz  = (dec != '0);
    wb      = big_q ? dec : {ecx_q[AW-1:16], dec16};
    sum     = next_eip_q + disp_q;
    target  = big_q ? sum : {{(AW-16){1'b0}}, sum[15:0]};

    jcc_cond = 1'b0;
    case (ir_q[3:1])
      3'd0: jcc_cond = vf_q;
      3'd1: jcc_cond = cf_q;
      3'd2: jcc_cond = zf_q;
      3'd3: jcc_cond = cf_q | zf_q;
      3'd4: jcc_cond = sf_q;
      3'd5: jcc_cond = pf_q;
      3'd6: jcc_cond = sf_q ^ vf_q;
      3'd7: jcc_cond = (sf_q ^ vf_q) | zf_q;
      default: jcc_cond = 1'b0;
    endcase

    cond = 1'b0;
    if (is_jcc)
      cond = jcc_cond ^ ir_q[0];
    else if (is_jmps)
      cond = 1'b1;
    else if (is_jcxz)
      cond = (cnt == '0);
    else if (ir_q == 8'hE2)
      cond = dec_nz;
    else if (ir_q == 8'hE1)
      cond = dec_nz && zf_q;
    else if (ir_q == 8'hE0)
      cond = dec_nz && !zf_q;
  end

  // Abort wins over every handshake and always returns the unit to IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      big_q       <= 1'b0;
      ir_q        <= '0;
      disp_q      <= '0;
      next_eip_q  <= '0;
      ecx_q       <= '0;
      zf_q        <= 1'b0;
      cf_q        <= 1'b0;
      sf_q        <= 1'b0;
      vf_q        <= 1'b0;
      pf_q        <= 1'b0;
      taken_q     <= 1'b0;
      redir_eip_q <= '0;
    end else if (abort_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            big_q      <= big_i;
            ir_q       <= ir_i;
            disp_q     <= disp_i;
            next_eip_q <= next_eip_i;
            ecx_q      <= ecx_i;
            zf_q       <= zf_i;
            cf_q       <= cf_i;
            sf_q       <= sf_i;
            vf_q       <= vf_i;
            pf_q       <= pf_i;
            state      <= EVAL;
          end
        end
        EVAL: begin
          taken_q <= cond;
          if (cond) begin
            redir_eip_q <= target;
            state       <= REDIR;
          end else begin
            state <= DONE;
          end
        end
        REDIR: begin
          if (redir_ready_i)
            state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready_o   = (state == IDLE);
  assign ecx_we_o      = (state == EVAL) && is_loop && !abort_i;
  assign ecx_o         = ecx_we_o ? wb : '0;
  assign redir_valid_o = (state == REDIR) && !abort_i;
  assign redir_eip_o   = redir_eip_q;
  assign done_o        = (state == DONE) && !abort_i;
  assign taken_o       = done_o && taken_q;

endmodule

// File: tb/tb_branch_exec.sv
// Randomised scoreboard bench for branch_exec: the driver queues expected
// write-backs, redirects and completions; a negedge monitor retires them.
module tb_branch_exec;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        abort_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        big_i = 1'b0;
  logic [7:0]  ir_i = '0;
  logic [31:0] disp_i = '0;
  logic [31:0] next_eip_i = '0;
  logic [31:0] ecx_i = '0;
  logic        zf_i = 1'b0, cf_i = 1'b0, sf_i = 1'b0, vf_i = 1'b0, pf_i = 1'b0;
  logic        ecx_we_o;
  logic [31:0] ecx_o;
  logic        redir_valid_o;
  logic        redir_ready_i = 1'b1;
  logic [31:0] redir_eip_o;
  logic        done_o;
  logic        taken_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct { int cyc; bit [31:0] val; } wr_exp_t;
  typedef struct { int first_cyc; int hs_cyc; bit [31:0] eip; bit seen; } redir_exp_t;
  typedef struct { int cyc; bit taken; } done_exp_t;

  wr_exp_t    exp_wr[$];
  redir_exp_t exp_redir[$];
  done_exp_t  exp_done[$];

  branch_exec #(.AW(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .abort_i(abort_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .big_i(big_i), .ir_i(ir_i), .disp_i(disp_i), .next_eip_i(next_eip_i),
    .ecx_i(ecx_i), .zf_i(zf_i), .cf_i(cf_i), .sf_i(sf_i), .vf_i(vf_i), .pf_i(pf_i),
    .ecx_we_o(ecx_we_o), .ecx_o(ecx_o),
    .redir_valid_o(redir_valid_o), .redir_ready_i(redir_ready_i),
    .redir_eip_o(redir_eip_o), .done_o(done_o), .taken_o(taken_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_unexpected(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=1 required=0 (cycle %0d)", name, cyc);
  endtask

  // x86 semantics, stated per opcode with the count taken modulo the operand size.
  function automatic void ref_model(input bit big, input bit [7:0] op,
                                    input bit [31:0] disp, input bit [31:0] nip,
                                    input bit [31:0] ecx, input bit [4:0] fl,
                                    output bit wr, output bit [31:0] ecx_new,
                                    output bit tk, output bit [31:0] tgt);
    bit zf = fl[4], cf = fl[3], sf = fl[2], vf = fl[1], pf = fl[0];
    longint unsigned modulus = big ? 64'h1_0000_0000 : 64'h1_0000;
    longint unsigned count = longint'(ecx) % modulus;
    longint unsigned nc = (count + modulus - 1) % modulus;
    wr = 0;
    tk = 0;
    ecx_new = ecx;
    case (op)
      8'h70: tk = vf;
      8'h71: tk = !vf;
      8'h72: tk = cf;
      8'h73: tk = !cf;
      8'h74: tk = zf;
      8'h75: tk = !zf;
      8'h76: tk = cf || zf;
      8'h77: tk = !(cf || zf);
      8'h78: tk = sf;
      8'h79: tk = !sf;
      8'h7A: tk = pf;
      8'h7B: tk = !pf;
      8'h7C: tk = (sf != vf);
      8'h7D: tk = (sf == vf);
      8'h7E: tk = zf || (sf != vf);
      8'h7F: tk = !(zf || (sf != vf));
      8'hEB: tk = 1;
      8'hE2: begin wr = 1; tk = (nc != 0); end
      8'hE1: begin wr = 1; tk = (nc != 0) && zf; end
      8'hE0: begin wr = 1; tk = (nc != 0) && !zf; end
      8'hE3: tk = (count == 0);
      default: tk = 0;
    endcase
    if (wr)
      ecx_new = big ? 32'(nc) : ((ecx & 32'hFFFF_0000) | 32'(nc));
    tgt = 32'((longint'(nip) + longint'(disp)) % modulus);
  endfunction

  always @(negedge clk_i) begin
    if (ecx_we_o) begin
      if (exp_wr.size() == 0) flag_unexpected("ecx_we_unexpected");
      else begin
        check_output("ecx_o", ecx_o, exp_wr[0].val);
        check_output("ecx_we_cycle", 32'(cyc), 32'(exp_wr[0].cyc));
        exp_wr.delete(0);
      end
    end
    if (redir_valid_o) begin
      if (exp_redir.size() == 0) flag_unexpected("redir_unexpected");
      else begin
        check_output("redir_eip_o", redir_eip_o, exp_redir[0].eip);
        if (!exp_redir[0].seen) begin
          check_output("redir_first_cycle", 32'(cyc), 32'(exp_redir[0].first_cyc));
          exp_redir[0].seen = 1;
        end
        if (redir_ready_i) begin
          check_output("redir_hs_cycle", 32'(cyc), 32'(exp_redir[0].hs_cyc));
          exp_redir.delete(0);
        end
      end
    end
    if (done_o) begin
      if (exp_done.size() == 0) flag_unexpected("done_unexpected");
      else begin
        check_output("taken_o", {31'b0, taken_o}, {31'b0, exp_done[0].taken});
        check_output("done_cycle", 32'(cyc), 32'(exp_done[0].cyc));
        exp_done.delete(0);
      end
    end
  end

  // kill_at: cycle offset after acceptance at which to abort (or reset); -1 = none.
  task automatic apply_stimulus(input bit big, input bit [7:0] op, input bit [31:0] disp,
                                input bit [31:0] nip, input bit [31:0] ecx, input bit [4:0] fl,
                                input int stall, input int kill_at, input bit kill_by_reset);
    bit wr, tk;
    bit [31:0] ev, tgt;
    int n, waited;
    bit killed;
    ref_model(big, op, disp, nip, ecx, fl, wr, ev, tk, tgt);
    redir_ready_i = (stall == 0);
    waited = 0;
    while (!req_ready_o && waited < 20) begin
      @(posedge clk_i); #1;
      waited++;
    end
    if (!req_ready_o) begin
      flag_unexpected("req_ready_timeout");
      return;
    end
    big_i = big; ir_i = op; disp_i = disp; next_eip_i = nip; ecx_i = ecx;
    {zf_i, cf_i, sf_i, vf_i, pf_i} = fl;
    req_valid_i = 1'b1;
    n = cyc;
    if (wr) exp_wr.push_back('{n + 1, ev});
    if (tk) exp_redir.push_back('{n + 2, n + 2 + stall, tgt, 1'b0});
    if (kill_at < 0) exp_done.push_back('{tk ? n + 3 + stall : n + 2, tk});
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    ecx_i = $urandom();
    killed = 0;
    for (int off = 1; off <= 2 + stall && !killed; off++) begin
      if (off == kill_at) begin
        killed = 1;
        if (kill_by_reset) begin
          rst_ni = 1'b0;
          #1;
          check_output("reset_mid_redir_valid", {31'b0, redir_valid_o}, 32'd0);
          check_output("reset_mid_ready", {31'b0, req_ready_o}, 32'd1);
          check_output("reset_mid_eip", redir_eip_o, 32'd0);
          @(posedge clk_i); #1;
          rst_ni = 1'b1;
        end else begin
          abort_i = 1'b1;
          #1;
          check_output("abort_redir_valid", {31'b0, redir_valid_o}, 32'd0);
          @(posedge clk_i); #1;
          abort_i = 1'b0;
          check_output("abort_ready_next", {31'b0, req_ready_o}, 32'd1);
        end
        exp_redir.delete();
        repeat (4) @(posedge clk_i);
        #1;
      end else begin
        if (off == 2 + stall) redir_ready_i = 1'b1;
        @(posedge clk_i); #1;
      end
    end
    redir_ready_i = 1'b1;
    waited = 0;
    while ((exp_wr.size() + exp_redir.size() + exp_done.size()) != 0 && waited < 40) begin
      @(posedge clk_i); #1;
      waited++;
    end
    if (waited >= 40) begin
      flag_unexpected("drain_timeout");
      exp_wr.delete(); exp_redir.delete(); exp_done.delete();
    end
  endtask

  initial begin
    bit [7:0]  op;
    bit [31:0] ecx, r;
    #12;
    check_output("reset_ready", {31'b0, req_ready_o}, 32'd1);
    check_output("reset_outputs", {28'b0, ecx_we_o, redir_valid_o, done_o, taken_o}, 32'd0);
    check_output("reset_ecx_o", ecx_o, 32'd0);
    check_output("reset_redir_eip", redir_eip_o, 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    $display("[TB] directed sequences");
    apply_stimulus(1, 8'h74, 32'hFFFF_FFF0, 32'h0000_1000, 32'h0, 5'b10000, 0, -1, 0);
    apply_stimulus(1, 8'h75, 32'h0000_0040, 32'h0000_2000, 32'h0, 5'b10000, 0, -1, 0);
    apply_stimulus(0, 8'hE2, 32'h0000_0010, 32'h0000_3000, 32'hABCD_0001, 5'b00000, 0, -1, 0);
    apply_stimulus(0, 8'hE2, 32'h0000_0020, 32'h0000_FFF0, 32'h1234_0000, 5'b00000, 0, -1, 0);
    apply_stimulus(1, 8'hE3, 32'h0000_0100, 32'h0040_0000, 32'h0, 5'b00000, 0, -1, 0);
    apply_stimulus(1, 8'hE0, 32'h0000_0100, 32'h0040_0000, 32'h5, 5'b10000, 0, -1, 0);
    apply_stimulus(1, 8'hEB, 32'h0000_0080, 32'h0050_0000, 32'h0, 5'b00000, 3, -1, 0);
    apply_stimulus(1, 8'hEB, 32'h0000_0080, 32'h0060_0000, 32'h0, 5'b00000, 3, 3, 0);
    apply_stimulus(1, 8'hE2, 32'h0000_0004, 32'h0070_0000, 32'h9, 5'b00000, 3, 3, 1);
    apply_stimulus(1, 8'hC3, 32'h0000_0004, 32'h0070_0000, 32'h9, 5'b11111, 0, -1, 0);

    $display("[TB] randomised sequences");
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      if (r < 5) op = 8'h70 | 8'($urandom_range(0, 15));
      else if (r == 5) op = 8'hEB;
      else if (r < 9) op = 8'hE0 | 8'($urandom_range(0, 3));
      else op = 8'($urandom());
      ecx = $urandom();
      if ($urandom_range(0, 2) == 0) ecx[15:0] = 16'($urandom_range(0, 2));
      if ($urandom_range(0, 5) == 0) ecx = 32'($urandom_range(0, 2));
      apply_stimulus(1'($urandom()), op, $urandom(), $urandom(), ecx, 5'($urandom()),
                     $urandom_range(0, 2), -1, 0);
    end

    repeat (3) @(posedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_exec.md
Name: branch_exec

Overview:
Sequential branch execution unit for the cpu_386 core.
- Accepts one decoded short branch per request: Jcc (70-7F), JMPS (EB), LOOP/LOOPZ/LOOPNZ (E2/E1/E0) or JCXZ (E3).
- Evaluates the condition internally against latched flags and count.
- Performs the ECX/CX decrement write-back for LOOP forms.
- Issues a redirect to the prefetch/fetch stage over a valid/ready handshake, then reports completion to the sequencer.

Parameters:
AW, 32, width of instruction-pointer and count datapath

Ports:
clk_i  in  1  core clock
rst_ni  in  1  asynchronous active-low reset
abort_i  in  1  synchronous flush from sequencer; cancels the in-flight branch
req_valid_i  in  1  branch request valid
req_ready_o  out  1  unit can accept a request
big_i  in  1  1 = 32-bit operand/address size, 0 = 16-bit
ir_i  in  8  branch opcode
disp_i  in  AW  displacement, already sign-extended
next_eip_i  in  AW  address of the instruction following the branch
ecx_i  in  AW  current ECX
zf_i, cf_i, sf_i, vf_i, pf_i  in  1 each  current flags
ecx_we_o  out  1  ECX write strobe
ecx_o  out  AW  ECX write-back value
redir_valid_o  out  1  redirect request
redir_ready_i  in  1  fetch accepts redirect
redir_eip_o  out  AW  branch target
done_o  out  1  one-cycle completion pulse
taken_o  out  1  branch taken; valid while done_o=1

Behaviour:
- Reset (rst_ni=0, asynchronous): state=IDLE.
  - req_ready_o=1.
  - ecx_we_o, redir_valid_o, done_o and taken_o are 0.
  - ecx_o and redir_eip_o are 0.
- States: IDLE, EVAL, REDIR, DONE.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i&&req_ready_o, latch big, ir, disp, next_eip, ecx and flags, then go to EVAL.
  - req_ready_o=0 in all other states.
- EVAL (exactly one cycle):
  - cnt = big ? ecx : ecx[15:0].
  - LOOP ops: dec = cnt-1, wrapping in the active width. 0 -> FFFF in 16-bit mode; 0 -> FFFFFFFF in 32-bit mode.
  - LOOP ops: ecx_we_o=1 for this cycle only. ecx_o = big ? dec : {ecx[31:16],dec[15:0]}, so the upper half is preserved in 16-bit mode.
  - Conditions: JMPS always. Jcc per x86 (JO vf, JB cf, JE zf, JBE cf|zf, JS sf, JP pf, JL sf^vf, JLE (sf^vf)|zf; odd opcodes are the inverse). LOOP dec!=0. LOOPZ dec!=0&&zf. LOOPNZ dec!=0&&!zf. JCXZ cnt==0 with no decrement.
  - Any other opcode: not taken, no write.
  - Target = next_eip+disp mod 2^AW. If !big, the target is truncated: {16'h0, sum[15:0]}.
  - Taken -> REDIR, with redir_eip_o loaded. Not taken -> DONE.
- REDIR:
  - redir_valid_o=1; redir_eip_o is held stable until redir_ready_i=1.
  - On the handshake cycle go to DONE; redir_valid_o drops the next cycle.
- DONE:
  - done_o=1 for one cycle; taken_o=the evaluated result.
  - Go to IDLE. A new request can be accepted on the following cycle.
- Latency, with acceptance at cycle N:
  - Not taken: done_o at N+2.
  - Taken with ready already high: redir_valid_o at N+2, done_o at N+3.
- abort_i, from any state: next state is IDLE.
  - redir_valid_o, done_o and ecx_we_o are forced 0 that cycle; no done pulse is produced.
  - An ECX write already issued in EVAL is not undone.
  - abort_i has priority over redir_ready_i in the same cycle.
  - In IDLE, abort_i blocks acceptance that cycle.
- Reset asserted mid-operation: immediate return to the reset state with no partial outputs.
- Back-to-back requests: not pipelined; one branch in flight at a time.

Test Plan:
1. JE (74), zf=1, big=1, next_eip=0x1000, disp=0xFFFFFFF0, redir_ready_i held 1.
   -> redir_valid_o at N+2 with redir_eip_o=0x00000FF0; done_o/taken_o=1 at N+3.
2. JNE (75), zf=1.
   -> no redir_valid_o; done_o=1 with taken_o=0 at N+2.
3. LOOP (E2), big=0, ecx=0xABCD0001.
   -> ecx_we_o pulse with ecx_o=0xABCD0000; not taken; done_o at N+2.
4. LOOP (E2), big=0, ecx=0x12340000, next_eip=0xFFF0, disp=0x20.
   -> ecx_o=0x1234FFFF; taken; redir_eip_o=0x00000010.
5. JCXZ (E3), big=1, ecx=0.
   -> taken, no ecx_we_o.
   Then LOOPNZ (E0), ecx=5, zf=1 -> ecx_o=4, not taken.
6. JMPS taken with redir_ready_i low for 3 cycles.
   -> redir_valid_o and redir_eip_o stable for 4 cycles, done_o the cycle after the handshake.
   Repeat with abort_i in the 2nd stall cycle -> IDLE, no done_o, req_ready_o=1 next cycle.
